// File: rtl/lbist_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared definitions for the logic-BIST sequencer:
//   - state_t          : sequencer state encoding
//   - DEF_*            : default configuration constants
//   - run_cycles()     : edges from the start-sampling edge to done=1
// -----------------------------------------------------------------------------
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT,
        CAPTURE,
        UNLOAD,
        COMPARE,
        DONE
    } state_t;

    localparam int unsigned DEF_CHAIN_LEN  = 32;
    localparam int unsigned DEF_N_PATTERNS = 1024;
    localparam int unsigned DEF_SIG_W      = 32;
    localparam int unsigned DEF_CNT_W      = 16;

    // INIT + N_PATTERNS * (SHIFT + CAPTURE) + UNLOAD + COMPARE
    function automatic int unsigned run_cycles(input int unsigned chain_len,
                                               input int unsigned n_patterns);
        return 1 + n_patterns * (chain_len + 1) + chain_len + 1;
    endfunction

endpackage

// File: rtl/lbist_cnt.sv
// -----------------------------------------------------------------------------
// lbist_cnt
// Up-counter with synchronous clear (load to zero) and terminal-count flag.
// Clear has priority over increment.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   i_clr  in   load counter with zero
//   i_inc  in   increment counter
//   o_tc   out  counter value equals TERM
// -----------------------------------------------------------------------------
module lbist_cnt
    import lbist_pkg::*;
#(
    parameter int unsigned    W    = DEF_CNT_W,
    parameter logic [W-1:0]   TERM = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == TERM);

endmodule

// File: rtl/lbist_ctrl.sv
// -----------------------------------------------------------------------------
// lbist_ctrl
// Logic-BIST sequencer: seeds the TPG, runs N_PATTERNS shift/capture patterns,
// one unload pass, then compares the MISR signature against GOLDEN_SIG.
// Optional feature macro: LBIST_ABORT_EN (adds the abort input).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a run (honoured in IDLE or DONE only)
//   abort      in   cancel a busy run (only with LBIST_ABORT_EN)
//   signature  in   current MISR contents
//   tpg_en     out  advance TPG LFSRs
//   tpg_rst_n  out  active-low TPG seed reload
//   scan_en    out  1 = shift, 0 = capture
//   misr_en    out  MISR compaction enable
//   test_mode  out  high whenever not IDLE
//   busy       out  high in INIT..COMPARE
//   done       out  run complete, held until next start/rst
//   pass       out  signature matched (valid with done)
// -----------------------------------------------------------------------------
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned      CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int unsigned      N_PATTERNS = DEF_N_PATTERNS,
    parameter int unsigned      SIG_W      = DEF_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0,
    parameter int unsigned      CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef LBIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [SIG_W-1:0] signature,
    output logic             tpg_en,
    output logic             tpg_rst_n,
    output logic             scan_en,
    output logic             misr_en,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] SH_TC  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PAT_TC = CNT_W'(N_PATTERNS - 1);

    state_t r_state;
    state_t w_next;
    logic   r_pass;
    logic   w_sh_tc;
    logic   w_pat_tc;
    logic   w_abort;
    logic   w_sh_clr;
    logic   w_sh_inc;
    logic   w_pat_clr;
    logic   w_pat_inc;

`ifdef LBIST_ABORT_EN
    assign w_abort = abort & busy;
`else
    assign w_abort = 1'b0;
`endif

    // Shift counter runs through SHIFT and UNLOAD and rewinds at each phase end
    assign w_sh_inc  = (r_state == SHIFT) || (r_state == UNLOAD);
    assign w_sh_clr  = (r_state == IDLE) || (r_state == INIT) || (w_sh_inc && w_sh_tc);
    assign w_pat_clr = (r_state == IDLE) || (r_state == INIT);
    assign w_pat_inc = (r_state == CAPTURE) && !w_pat_tc;

    lbist_cnt #(.W(CNT_W), .TERM(SH_TC)) u_sh_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_sh_clr),
        .i_inc (w_sh_inc),
        .o_tc  (w_sh_tc)
    );

    lbist_cnt #(.W(CNT_W), .TERM(PAT_TC)) u_pat_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_pat_clr),
        .i_inc (w_pat_inc),
        .o_tc  (w_pat_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = INIT;
            INIT:    w_next = SHIFT;
            SHIFT:   if (w_sh_tc) w_next = CAPTURE;
            CAPTURE: w_next = w_pat_tc ? UNLOAD : SHIFT;
            UNLOAD:  if (w_sh_tc) w_next = COMPARE;
            COMPARE: w_next = DONE;
            DONE:    if (start) w_next = INIT;
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = IDLE;
        end
    end

    // Verdict is latched in COMPARE and dropped when a new run starts or is aborted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (r_state == COMPARE) begin
            r_pass <= (signature == GOLDEN_SIG);
        end else if (w_next == INIT || w_abort) begin
            r_pass <= 1'b0;
        end
    end

    // Output decode
    always_comb begin
        tpg_en    = 1'b0;
        tpg_rst_n = 1'b1;
        scan_en   = 1'b0;
        misr_en   = 1'b0;
        test_mode = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                test_mode = 1'b0;
                busy      = 1'b0;
            end
            INIT:    tpg_rst_n = 1'b0;
            SHIFT: begin
                tpg_en  = 1'b1;
                scan_en = 1'b1;
                misr_en = 1'b1;
            end
            UNLOAD: begin
                scan_en = 1'b1;
                misr_en = 1'b1;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign pass = r_pass;

endmodule

// File: tb/tb_lbist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lbist_ctrl
// Scoreboarded bench for lbist_ctrl. Two instances:
//   A: CHAIN_LEN=4, N_PATTERNS=3 (run length 21 edges)
//   B: CHAIN_LEN=1, N_PATTERNS=1 (run length 5 edges)
// Build with +define+LBIST_ABORT_EN to also exercise abort.
// -----------------------------------------------------------------------------
module tb_lbist_ctrl;
    import lbist_pkg::*;

    localparam logic [31:0] GOLD_A = 32'hCAFE_F00D;
    localparam logic [31:0] GOLD_B = 32'h1234_5678;

    // Output vector order: tpg_en, tpg_rst_n, scan_en, misr_en, test_mode, busy, done, pass
    localparam logic [7:0] O_IDLE  = 8'h40;
    localparam logic [7:0] O_INIT  = 8'h0C;
    localparam logic [7:0] O_SHIFT = 8'hFC;
    localparam logic [7:0] O_CAPT  = 8'h4C;
    localparam logic [7:0] O_UNLD  = 8'h7C;
    localparam logic [7:0] O_CMP   = 8'h4C;
    localparam logic [7:0] O_DPASS = 8'h4B;
    localparam logic [7:0] O_DFAIL = 8'h4A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_start = 1'b0, b_start = 1'b0;
    logic [31:0] a_sig = GOLD_A, b_sig = GOLD_B;
    logic        a_tpg_en, a_tpg_rst_n, a_scan_en, a_misr_en, a_test_mode, a_busy, a_done, a_pass;
    logic        b_tpg_en, b_tpg_rst_n, b_scan_en, b_misr_en, b_test_mode, b_busy, b_done, b_pass;
`ifdef LBIST_ABORT_EN
    logic        a_abort = 1'b0, b_abort = 1'b0;
`endif
    logic [7:0]  a_outs, b_outs;

    assign a_outs = {a_tpg_en, a_tpg_rst_n, a_scan_en, a_misr_en, a_test_mode, a_busy, a_done, a_pass};
    assign b_outs = {b_tpg_en, b_tpg_rst_n, b_scan_en, b_misr_en, b_test_mode, b_busy, b_done, b_pass};

    lbist_ctrl #(.CHAIN_LEN(4), .N_PATTERNS(3), .SIG_W(32), .GOLDEN_SIG(GOLD_A), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(a_start),
`ifdef LBIST_ABORT_EN
        .abort(a_abort),
`endif
        .signature(a_sig), .tpg_en(a_tpg_en), .tpg_rst_n(a_tpg_rst_n), .scan_en(a_scan_en),
        .misr_en(a_misr_en), .test_mode(a_test_mode), .busy(a_busy), .done(a_done), .pass(a_pass)
    );

    lbist_ctrl #(.CHAIN_LEN(1), .N_PATTERNS(1), .SIG_W(32), .GOLDEN_SIG(GOLD_B), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .start(b_start),
`ifdef LBIST_ABORT_EN
        .abort(b_abort),
`endif
        .signature(b_sig), .tpg_en(b_tpg_en), .tpg_rst_n(b_tpg_rst_n), .scan_en(b_scan_en),
        .misr_en(b_misr_en), .test_mode(b_test_mode), .busy(b_busy), .done(b_done), .pass(b_pass)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected completion for each issued start
    typedef struct {
        int   start_edge;
        int   lat;
        logic pass;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic a_done_q = 1'b0, b_done_q = 1'b0;

    always @(negedge clk) begin
        if (a_done && !a_done_q) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                ea = qa.pop_front();
                check("a_done_latency", 64'(cyc - ea.start_edge), 64'(ea.lat));
                check("a_pass", a_pass, ea.pass);
            end
        end
        if (b_done && !b_done_q) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                eb = qb.pop_front();
                check("b_done_latency", 64'(cyc - eb.start_edge), 64'(eb.lat));
                check("b_pass", b_pass, eb.pass);
            end
        end
        a_done_q = a_done;
        b_done_q = b_done;
    end

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int budget);
        for (int i = 0; i < budget && !a_done; i++) step();
        check("a_done_within_budget", a_done, 1'b1);
    endtask

    // Full run on instance A from IDLE/DONE, with waveform checks
    task automatic run_a(input logic [31:0] sig, input logic exp_pass);
        logic [21:0] scan_seq;
        int          tpg_cnt;
        scan_seq = '0;
        tpg_cnt  = 0;
        a_sig    = sig;
        a_start  = 1'b1;
        step();
        a_start  = 1'b0;
        qa.push_back('{cyc, 21, exp_pass});
        check("a_init_outputs", a_outs, O_INIT);
        scan_seq[0] = a_scan_en;
        for (int n = 1; n <= 21; n++) begin
            step();
            scan_seq[n] = a_scan_en;
            tpg_cnt += int'(a_tpg_en);
        end
        check("a_scan_en_wave", scan_seq, 22'b0011110111101111011110);
        check("a_tpg_en_cycles", tpg_cnt, 12);
        check("a_done_outputs", a_outs, exp_pass ? O_DPASS : O_DFAIL);
    endtask

    logic [7:0] b_tbl [6];
    logic       held_ok;

    initial begin
        b_tbl = '{O_INIT, O_SHIFT, O_CAPT, O_UNLD, O_CMP, O_DPASS};

        // Reset for two cycles
        rst = 1'b1;
        step();
        step();
        check("a_reset_outputs", a_outs, O_IDLE);
        check("b_reset_outputs", b_outs, O_IDLE);
        rst = 1'b0;

        // Reset in the middle of SHIFT
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        step();
        check("a_in_shift_before_rst", a_outs, O_SHIFT);
        rst = 1'b1;
        step();
        check("a_rst_midrun", a_outs, O_IDLE);
        rst = 1'b0;
        step();
        check("a_idle_after_rst", a_outs, O_IDLE);

        // Nominal run with matching signature
        run_a(GOLD_A, 1'b1);

        // Mismatch run; verdict must hold while idle
        run_a(GOLD_A ^ 32'h1, 1'b0);
        held_ok = 1'b1;
        repeat (10) begin
            step();
            if (!(a_done === 1'b1 && a_pass === 1'b0)) held_ok = 1'b0;
        end
        check("a_mismatch_held_10", held_ok, 1'b1);

        // start held high through a whole run must not restart it
        a_sig   = GOLD_A;
        a_start = 1'b1;
        step();
        qa.push_back('{cyc, 21, 1'b1});
        wait_done_a(40);
        a_start = 1'b0;
        step();
        check("a_done_hold", a_outs, O_DPASS);

        // start in DONE: done/pass drop, TPG reseed for exactly one cycle
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        qa.push_back('{cyc, 21, 1'b1});
        check("a_restart_from_done", a_outs, O_INIT);
        step();
        check("a_tpg_rst_one_cycle", a_tpg_rst_n, 1'b1);
        wait_done_a(40);

        // Minimum configuration: every state visited exactly once
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        qb.push_back('{cyc, 5, 1'b1});
        check("b_state_0", b_outs, b_tbl[0]);
        for (int n = 1; n <= 5; n++) begin
            step();
            check($sformatf("b_state_%0d", n), b_outs, b_tbl[n]);
        end

`ifdef LBIST_ABORT_EN
        // Abort in the second CAPTURE, then a full normal run
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (10) step();
        check("a_second_capture", a_outs, O_CAPT);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("a_abort_idle", a_outs, O_IDLE);
        step();
        check("a_abort_stays_idle", a_outs, O_IDLE);
        run_a(GOLD_A, 1'b1);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("a_abort_ignored_in_done", a_outs, O_DPASS);
`endif

        step();
        step();
        check("a_scoreboard_drained", qa.size(), 0);
        check("b_scoreboard_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
